i2c_temp_sensor_slave: RTL and testbench
========================================

Name: i2c_temp_sensor_slave

Overview:
- I2C responder that models the PmodTMP2 temperature sensor on the target side of the bus.
- Answers 7-bit address SENSOR_ADDR read transactions with a 2-byte big-endian temperature word, MSB first.
- Sits in the Basys 3 design as a stand-in sensor for bring-up and loopback against the existing I2C master. Also usable as the bus model in simulation.
- Oversamples SCL/SDA on the 100 MHz system clock. Never drives SCL: no clock stretching.

Parameters:
- SENSOR_ADDR, 7'h4B, 7-bit target address; the read byte on the bus is 0x97.
- FILT_CYCLES, 4, clocks an input must be stable before it is accepted; used only with I2C_GLITCH_FILTER_EN.

Ports:
- clk_100MHz  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- SCL  input  1  I2C clock from master
- SDA  inout  1  I2C data; open-drain, driven 0 or 'z' only
- temp_in  input  16  temperature word to report, {MSB, LSB}
- busy  output  1  high while addressed (ADDR_ACK through RX_MACK)
- addr_hit  output  1  one-cycle pulse when a matching read address is ACKed
- rd_done  output  1  one-cycle pulse when the master NACKs a data byte

Behaviour:
- Reset is asynchronous: SDA released ('z'), state IDLE, busy/addr_hit/rd_done = 0, shift register and bit count = 0.
- Input conditioning:
  - SCL and SDA each pass through a 2-FF synchronizer.
  - Edges are detected on the synchronized values: scl_rise, scl_fall.
- Bus conditions:
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Detected in every state; both have priority over the state's own transitions.
  - START (including repeated START) -> ADDR, bit count cleared, SDA released.
  - STOP -> IDLE, SDA released.
- Data timing:
  - Received bits are sampled on scl_rise.
  - Driven bits change only on scl_fall, i.e. 3 clocks after the pin edge, giving 30 ns hold.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise. On the 8th scl_fall:
    - addr[7:1] == SENSOR_ADDR and R/W = 1: drive SDA low -> ADDR_ACK.
    - Address match with R/W = 0: leave SDA released (NACK) -> WAIT_STOP. No write support.
    - Address mismatch: -> WAIT_STOP.
  - ADDR_ACK: hold SDA low through the 9th SCL high. On the 9th scl_fall: snapshot temp_in into tx_word, pulse addr_hit, byte_sel = 0, drive tx_word[15] -> TX_BYTE.
  - TX_BYTE:
    - On each scl_fall, drive the next bit of the selected byte: MSB byte when byte_sel = 0, LSB byte when byte_sel = 1.
    - Bit value 0 drives SDA low; bit value 1 releases SDA.
    - After the 8th bit's scl_fall, release SDA -> RX_MACK.
  - RX_MACK:
    - Sample SDA on the 9th scl_rise.
    - Sampled 0 (ACK): toggle byte_sel; on scl_fall drive the first bit of the next byte -> TX_BYTE. After the LSB byte this wraps to the MSB byte of the same snapshot; temp_in is not re-sampled.
    - Sampled 1 (NACK): pulse rd_done -> WAIT_STOP.
  - WAIT_STOP: SDA released; ignore traffic until START or STOP.
- busy is high in ADDR_ACK, TX_BYTE and RX_MACK.
- The snapshot makes each transaction coherent: temp_in changes after addr_hit do not affect the bytes sent.
- The bit counter is 3 bits and wraps 7 -> 0 at each byte boundary.

Optional Feature:
- Macro: I2C_GLITCH_FILTER_EN.
- Defined: after synchronization, SCL and SDA each go through a saturating counter filter. The filtered value changes only after the raw input has differed from it for FILT_CYCLES consecutive clocks, which suppresses spikes shorter than FILT_CYCLES × 10 ns.
  - Added latency: FILT_CYCLES clocks on both lines.
  - SCL and SDA are delayed equally, so START/STOP detection is preserved.
- Undefined: synchronizer output is used directly.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, TX_BYTE, RX_MACK, WAIT_STOP);
  - the default SENSOR_ADDR constant 7'h4B;
  - the R/W bit encoding constants.
- One sub-module: i2c_line_cond (synchronizer + optional glitch filter + edge detect). Instantiated once each for SCL and SDA; outputs level, rise, fall.

Test Plan:
- Read, basic: temp_in = 16'h1A80; master sends START, 0x97, ACKs MSB, NACKs LSB, STOP -> SDA low on 9th clock; bytes read 0x1A then 0x80; addr_hit and rd_done each pulse once; busy drops after NACK.
- Wrong address or write: START + 0x91, then START + 0x96 -> SDA never driven low, no addr_hit, state WAIT_STOP until STOP.
- Continued read and coherency: temp_in = 16'h1980, master ACKs MSB and LSB and reads 3 bytes; temp_in changed to 16'h2000 after addr_hit -> bytes 0x19, 0x80, 0x19.
- Bus conditions: repeated START inserted mid-MSB byte then 0x97 -> fresh transfer with new snapshot. reset_n low mid-TX_BYTE -> SDA 'z' in the same cycle, busy = 0, IDLE after release.
- Glitch filter (I2C_GLITCH_FILTER_EN, FILT_CYCLES = 4): 20 ns SCL spike during a data bit -> no bit advance. Same spike without the macro -> bit counter advances (documents the difference).

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_pkg : shared types and constants for the I2C temperature-sensor target
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    TX_BYTE   = 3'd3,
    RX_MACK   = 3'd4,
    WAIT_STOP = 3'd5
  } i2c_state_e;

  localparam logic [6:0] SENSOR_ADDR_DEFAULT = 7'h4B;
  localparam logic       RW_WRITE            = 1'b0;
  localparam logic       RW_READ             = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_line_cond.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_line_cond : 2-FF synchronizer, optional glitch filter, edge detector.
// Optional: I2C_GLITCH_FILTER_EN adds a FILT_CYCLES saturating-count filter.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module i2c_line_cond
`ifdef I2C_GLITCH_FILTER_EN
#(
  parameter int FILT_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       cond;
  logic       prev;

  // Reset to the idle-bus level so release from reset creates no false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], din};
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(FILT_CYCLES - 1)) begin
      filt <= sync[1];
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign cond = filt;
`else
  assign cond = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= cond;
  end

  assign level = cond;
  assign rise  = cond & ~prev;
  assign fall  = ~cond & prev;

endmodule
`default_nettype wire

// File: rtl/i2c_temp_sensor_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2c_temp_sensor_slave : read-only I2C target returning a 16-bit temperature
// word MSB first. Optional: I2C_GLITCH_FILTER_EN (SCL/SDA spike filter).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module i2c_temp_sensor_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SENSOR_ADDR = SENSOR_ADDR_DEFAULT
`ifdef I2C_GLITCH_FILTER_EN
  , parameter int FILT_CYCLES = 4
`endif
)(
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        SCL,
  inout  wire         SDA,
  input  logic [15:0] temp_in,
  output logic        busy,
  output logic        addr_hit,
  output logic        rd_done
);

  i2c_state_e  state, state_nx;
  logic        scl_lvl, scl_rise, scl_fall;
  logic        sda_lvl, sda_rise, sda_fall;
  logic        start_c, stop_c;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        last_bit;
  logic [15:0] tx_word;
  logic        byte_sel;
  logic        sda_low;
  logic [7:0]  cur_byte;
  logic [2:0]  nxt_idx;
  logic        addr_rd_match;

  i2c_line_cond
`ifdef I2C_GLITCH_FILTER_EN
    #(.FILT_CYCLES(FILT_CYCLES))
`endif
    u_scl_cond (.clk(clk_100MHz), .rst_n(reset_n), .din(SCL),
                .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));

  i2c_line_cond
`ifdef I2C_GLITCH_FILTER_EN
    #(.FILT_CYCLES(FILT_CYCLES))
`endif
    u_sda_cond (.clk(clk_100MHz), .rst_n(reset_n), .din(SDA),
                .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start_c       = sda_fall & scl_lvl;
  assign stop_c        = sda_rise & scl_lvl;
  assign cur_byte      = byte_sel ? tx_word[7:0] : tx_word[15:8];
  assign nxt_idx       = ~(bit_cnt + 3'd1);
  assign addr_rd_match = (shift[7:1] == SENSOR_ADDR) && (shift[0] == RW_READ);
  assign SDA           = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start_c) begin
      state_nx = ADDR;
    end else if (stop_c) begin
      state_nx = IDLE;
    end else begin
      case (state)
        ADDR:     if (scl_fall && last_bit) state_nx = addr_rd_match ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall) state_nx = TX_BYTE;
        TX_BYTE:  if (scl_fall && bit_cnt == 3'd7) state_nx = RX_MACK;
        RX_MACK: begin
          if (scl_rise && sda_lvl) state_nx = WAIT_STOP;
          else if (scl_fall)       state_nx = TX_BYTE;
        end
        default:  state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy     = (state == ADDR_ACK) || (state == TX_BYTE) || (state == RX_MACK);
    addr_hit = (state == ADDR_ACK) && scl_fall && !start_c && !stop_c;
    rd_done  = (state == RX_MACK) && scl_rise && sda_lvl && !start_c && !stop_c;
  end

  // sda_low only ever changes on scl_fall (or bus conditions), keeping data hold.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      shift    <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      tx_word  <= '0;
      byte_sel <= 1'b0;
      sda_low  <= 1'b0;
    end else if (start_c) begin
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      sda_low  <= 1'b0;
    end else if (stop_c) begin
      sda_low  <= 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift    <= {shift[6:0], sda_lvl};
            bit_cnt  <= bit_cnt + 3'd1;
            last_bit <= (bit_cnt == 3'd7);
          end else if (scl_fall && last_bit) begin
            last_bit <= 1'b0;
            sda_low  <= addr_rd_match;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            tx_word  <= temp_in;
            byte_sel <= 1'b0;
            bit_cnt  <= '0;
            sda_low  <= ~temp_in[15];
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
            end else begin
              sda_low <= ~cur_byte[nxt_idx];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        RX_MACK: begin
          if (scl_rise) begin
            if (!sda_lvl) byte_sel <= ~byte_sel;
          end else if (scl_fall) begin
            sda_low <= ~cur_byte[7];
          end
        end
        default: sda_low <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_temp_sensor_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_i2c_temp_sensor_slave : bus-level master driving the sensor target,
// checked against a snapshot/byte-order reference model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_i2c_temp_sensor_slave;

  localparam int H = 200;
  localparam int Q = 50;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda_low = 1'b0;
  logic [15:0] temp_in = 16'h0000;
  logic        busy, addr_hit, rd_done;
  wire         sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_cnt  = 0;
  int done_cnt = 0;
  int dut_low_cnt = 0;

  i2c_temp_sensor_slave dut (
    .clk_100MHz(clk), .reset_n(reset_n), .SCL(scl), .SDA(sda_bus),
    .temp_in(temp_in), .busy(busy), .addr_hit(addr_hit), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (addr_hit) hit_cnt++;
    if (rd_done)  done_cnt++;
    if (!m_sda_low && sda_bus === 1'b0) dut_low_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- master primitives ----------------
  task automatic bus_start();
    m_sda_low = 1'b0; #Q; scl = 1'b1; #H; m_sda_low = 1'b1; #H; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #(H-Q); scl = 1'b1; #H; m_sda_low = 1'b0; #H;
  endtask

  task automatic bit_xfer(input logic tx, output logic rx);
    m_sda_low = !tx;
    #(H-Q); scl = 1'b1; #(H/2); rx = sda_bus; #(H/2); scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_n);
    logic d;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
    bit_xfer(1'b1, ack_n);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic r;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, r);
      b = {b[6:0], r};
    end
    bit_xfer(nack, r);
  endtask

  // Reference: byte n of a read returns MSB for even n, LSB for odd n of the snapshot.
  function automatic logic [7:0] model_byte(input logic [15:0] snap, input int n);
    return (n % 2 == 0) ? snap[15:8] : snap[7:0];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (addr_hit !== 1'b0 || rd_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", addr_hit, rd_done); end
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda_bus); end
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic_read();
    logic a; logic [7:0] b;
    int h0 = hit_cnt, d0 = done_cnt;
    temp_in = 16'h1A80;
    bus_start();
    write_byte(8'h97, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL basic_addr_ack: got %b expected 0", a); end
    n_checks++; if (hit_cnt != h0 + 1) begin n_fail++; $display("FAIL basic_addr_hit: got %0d expected %0d", hit_cnt - h0, 1); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_tx: got %b expected 1", busy); end
    read_byte(b, 1'b0);
    n_checks++; if (b !== 8'h1A) begin n_fail++; $display("FAIL basic_msb: got %h expected 1a", b); end
    read_byte(b, 1'b1);
    n_checks++; if (b !== 8'h80) begin n_fail++; $display("FAIL basic_lsb: got %h expected 80", b); end
    n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL basic_rd_done: got %0d expected 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    bus_stop();
    n_checks++; if (hit_cnt != h0 + 1) begin n_fail++; $display("FAIL basic_hit_once: got %0d expected 1", hit_cnt - h0); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    int h0 = hit_cnt;
    dut_low_cnt = 0;
    bus_start();
    write_byte(8'h91, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_nack: got %b expected 1", a); end
    bus_start();
    write_byte(8'h96, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL write_nack: got %b expected 1", a); end
    write_byte(8'h00, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL wait_stop_ignore: got %b expected 1", a); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_busy: got %b expected 0", busy); end
    bus_stop();
    n_checks++; if (dut_low_cnt != 0) begin n_fail++; $display("FAIL wrong_sda_driven: got %0d low cycles expected 0", dut_low_cnt); end
    n_checks++; if (hit_cnt != h0) begin n_fail++; $display("FAIL wrong_addr_hit: got %0d expected 0", hit_cnt - h0); end
  endtask

  task automatic test_coherency();
    logic a; logic [7:0] b;
    logic [7:0] exp_b [3] = '{8'h19, 8'h80, 8'h19};
    temp_in = 16'h1980;
    bus_start();
    write_byte(8'h97, a);
    temp_in = 16'h2000;
    for (int i = 0; i < 3; i++) begin
      read_byte(b, i == 2);
      n_checks++; if (b !== exp_b[i]) begin n_fail++; $display("FAIL coherent_byte%0d: got %h expected %h", i, b, exp_b[i]); end
    end
    bus_stop();
  endtask

  task automatic test_random_reads();
    logic a; logic [7:0] b; logic [15:0] snap; int nb, h0, d0;
    for (int it = 0; it < 6; it++) begin
      snap = 16'($urandom);
      nb   = $urandom_range(1, 5);
      h0 = hit_cnt; d0 = done_cnt;
      temp_in = snap;
      bus_start();
      write_byte(8'h97, a);
      n_checks++; if (a !== 1'b0 || hit_cnt != h0 + 1) begin n_fail++; $display("FAIL rand_addr it%0d: got ack=%b hits=%0d expected ack=0 hits=1", it, a, hit_cnt - h0); end
      temp_in = 16'($urandom);
      for (int i = 0; i < nb; i++) begin
        read_byte(b, i == nb - 1);
        n_checks++; if (b !== model_byte(snap, i)) begin n_fail++; $display("FAIL rand_byte it%0d n%0d: got %h expected %h", it, i, b, model_byte(snap, i)); end
      end
      bus_stop();
      n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL rand_rd_done it%0d: got %0d expected 1", it, done_cnt - d0); end
    end
  endtask

  task automatic test_repeated_start();
    logic a, r; logic [7:0] b; logic [15:0] ta, tb;
    logic [2:0] got;
    int h0 = hit_cnt;
    ta = {5'b11111, 11'($urandom)};
    tb = 16'($urandom);
    temp_in = ta;
    bus_start();
    write_byte(8'h97, a);
    for (int i = 0; i < 3; i++) begin bit_xfer(1'b1, r); got[2-i] = r; end
    n_checks++; if (got !== 3'b111) begin n_fail++; $display("FAIL rs_partial: got %b expected 111", got); end
    temp_in = tb;
    bus_start();
    write_byte(8'h97, a);
    n_checks++; if (a !== 1'b0 || hit_cnt != h0 + 2) begin n_fail++; $display("FAIL rs_readdr: got ack=%b hits=%0d expected ack=0 hits=2", a, hit_cnt - h0); end
    read_byte(b, 1'b0);
    n_checks++; if (b !== tb[15:8]) begin n_fail++; $display("FAIL rs_msb: got %h expected %h", b, tb[15:8]); end
    read_byte(b, 1'b1);
    n_checks++; if (b !== tb[7:0]) begin n_fail++; $display("FAIL rs_lsb: got %h expected %h", b, tb[7:0]); end
    bus_stop();
  endtask

  task automatic test_reset_mid_tx();
    logic a, r; logic [7:0] b; logic [15:0] t2;
    temp_in = 16'h0000;
    bus_start();
    write_byte(8'h97, a);
    for (int i = 0; i < 3; i++) bit_xfer(1'b1, r);
    n_checks++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL rst_pre_sda: got %b expected 0", sda_bus); end
    #17; reset_n = 1'b0; #1;
    n_checks++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL rst_sda_release: got %b expected 1", sda_bus); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    repeat (4) @(posedge clk);
    reset_n = 1'b1;
    #Q;
    bus_stop();
    t2 = 16'($urandom);
    temp_in = t2;
    bus_start();
    write_byte(8'h97, a);
    read_byte(b, 1'b1);
    n_checks++; if (b !== t2[15:8]) begin n_fail++; $display("FAIL rst_recover: got %h expected %h", b, t2[15:8]); end
    bus_stop();
  endtask

  task automatic test_spike();
    logic a, r; logic [7:0] b, e, msb; int k, nb, p, d0;
    msb = 8'($urandom);
    k   = $urandom_range(2, 7);
    nb  = 8 - k;
    d0  = done_cnt;
    temp_in = {msb, 8'($urandom)};
    bus_start();
    write_byte(8'h97, a);
    b = '0;
    for (int i = 0; i < nb; i++) begin bit_xfer(1'b1, r); b = {b[6:0], r}; end
    #Q; scl = 1'b1; #20; scl = 1'b0;
    for (int i = nb; i < 8; i++) begin bit_xfer(1'b1, r); b = {b[6:0], r}; end
    bit_xfer(1'b1, r);
`ifdef I2C_GLITCH_FILTER_EN
    e = msb;
`else
    // Unfiltered spike is an extra falling edge: one bit skipped, released one clock early.
    e = '0; p = 7;
    for (int j = 7; j >= k; j--) begin e[p] = msb[j]; p = p - 1; end
    for (int j = k - 2; j >= 0; j--) begin e[p] = msb[j]; p = p - 1; end
    e[0] = 1'b1;
`endif
    n_checks++; if (b !== e) begin n_fail++; $display("FAIL spike_byte k=%0d: got %h expected %h", k, b, e); end
    n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL spike_rd_done: got %0d expected 1", done_cnt - d0); end
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_wrong_addr();
    test_coherency();
    test_random_reads();
    test_repeated_start();
    test_reset_mid_tx();
    test_spike();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
